// File: rtl/inst_fetch.sv
// inst_fetch: MIPS32 fetch unit keeping one instruction read in flight; define FETCH_ADEL_CHECK_EN to turn misaligned PCs into faulting nops
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        inst_ready,
    input  logic        full,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        inst_valid,
    output logic        fetch_adel
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, DRAIN} state_t;
    state_t state, state_nxt;
    logic [31:0] pc, pc_nxt, br_target, addr;
    logic br_pend, discard, handoff, capture, start, fault;
    logic unused_ok;
    assign unused_ok = &{1'b0, stall[5:1]};
    assign handoff = inst_valid && inst_ready && !full && !flush;
    assign capture = branch_flag_i && !stall[0];
    assign start = !stall[0] && ((state == IDLE && !full && !flush) || handoff);
    assign pc_nxt = flush ? new_pc : !handoff ? pc : capture ? branch_target_address_i : br_pend ? br_target : pc + 32'd4;
`ifdef FETCH_ADEL_CHECK_EN
    assign fault = start && pc_nxt[1:0] != 2'b00;
`else
    assign fault = 1'b0;
`endif
    assign inst_req = state == ADDR;
    assign inst_addr = inst_req ? addr : 32'd0;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !start ? IDLE : fault ? HOLD : ADDR;
            ADDR:    state_nxt = !inst_addr_ok ? ADDR : (discard || flush) ? DRAIN : DATA;
            DATA:    state_nxt = flush ? (inst_data_ok ? IDLE : DRAIN) : inst_data_ok ? HOLD : DATA;
            HOLD:    state_nxt = flush ? IDLE : !handoff ? HOLD : !start ? IDLE : fault ? HOLD : ADDR;
            DRAIN:   state_nxt = inst_data_ok ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    // the bus address is latched so a flush during ADDR cannot disturb the pending request
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            br_pend <= 1'b0;
            br_target <= 32'd0;
            addr <= 32'd0;
            discard <= 1'b0;
            if_pc <= 32'd0;
            if_inst <= 32'd0;
            inst_valid <= 1'b0;
            fetch_adel <= 1'b0;
        end else begin
            pc <= pc_nxt;
            br_pend <= !flush && !handoff && (br_pend || capture);
            if (capture) br_target <= branch_target_address_i;
            discard <= state == ADDR && !inst_addr_ok && (discard || flush);
            if (start) addr <= {pc_nxt[31:2], 2'b00};
            if (flush) begin
                inst_valid <= 1'b0;
                fetch_adel <= 1'b0;
            end else if (state == DATA && inst_data_ok) begin
                if_inst <= inst_rdata;
                if_pc <= pc;
                inst_valid <= 1'b1;
            end else if (fault) begin
                if_inst <= 32'd0;
                if_pc <= pc_nxt;
                inst_valid <= 1'b1;
                fetch_adel <= 1'b1;
            end else if (handoff) begin
                inst_valid <= 1'b0;
                fetch_adel <= 1'b0;
            end
        end
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit of the MIPS32 pipeline: holds the PC, issues one instruction read at a time on the instruction-side bus toward the AXI read adaptor, and presents the fetched word with its address to `if_id` as `if_pc`/`if_inst`/`inst_valid`. It obeys `if_id`'s `inst_ready`/`full` back-pressure, CTRL's `stall`/`flush`, and branch redirects from ID. It drains and discards any read left outstanding by a flush.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC00000, PC value loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high (`RstEnable` = 1).
- `stall`  in  6  CTRL stall vector; bit 0 = PC/fetch stage stall.
- `flush`  in  1  exception flush from CTRL.
- `new_pc`  in  32  exception handler address, valid with `flush`.
- `branch_flag_i`  in  1  ID requests redirect.
- `branch_target_address_i`  in  32  redirect target.
- `inst_ready`  in  1  `if_id` can accept an instruction.
- `full`  in  1  `if_id` holds a saved instruction; do not hand off or request.
- `inst_req`  out  1  read request, address phase.
- `inst_addr`  out  32  read address.
- `inst_addr_ok`  in  1  address phase accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  32  read data.
- `if_pc`  out  32  address of presented instruction.
- `if_inst`  out  32  presented instruction.
- `inst_valid`  out  1  `if_pc`/`if_inst` valid.
- `fetch_adel`  out  1  presented word is an address-error fetch (see Configuration).

## Operation
- Registers: `pc`, `br_pend`/`br_target`, state, `if_pc`, `if_inst`, `inst_valid`, `fetch_adel`.
- Handoff: a cycle with `inst_valid && inst_ready && !full && !flush`.
- Next PC at handoff: `br_target` if `br_pend`, else `pc + 4` (mod 2^32, wraps). `br_pend` is cleared at handoff.
- Branch capture: `branch_flag_i && !stall[0]` sets `br_pend`, `br_target <= branch_target_address_i`. If capture and handoff coincide, the captured target is used and `br_pend` stays clear.
- States:
  - IDLE. Go to ADDR when `!stall[0] && !full && !flush`.
  - ADDR. `inst_req`=1, `inst_addr`=`pc`, both held stable until `inst_addr_ok`. Then go to DATA, or to DRAIN if a flush was seen while in ADDR.
  - DATA. On `inst_data_ok`: latch `if_inst <= inst_rdata`, `if_pc <= pc`, `inst_valid <= 1`, go to HOLD.
  - HOLD. `inst_valid`=1, outputs frozen. On handoff: `inst_valid <= 0`, PC advances, go to ADDR if `!stall[0]`, else IDLE.
  - DRAIN. Wait for `inst_data_ok`, discard the data, go to IDLE.
- Flush (highest priority, any state):
  - `pc <= new_pc`, `br_pend <= 0`, `inst_valid <= 0`.
  - ADDR: request is kept asserted (no withdrawal) and marked discard.
  - DATA: go to DRAIN. If `inst_data_ok` arrives the same cycle, the data is dropped and the next state is IDLE.
  - HOLD/IDLE: go to IDLE.
- `rst` mid-transaction: everything returns to reset state; the bus adaptor is reset by the same `rst`, so no drain is needed.

## Timing
- Reset values: `pc`=`RESET_PC`, state IDLE, `inst_req`=0, `inst_addr`=0, `if_pc`=0, `if_inst`=0, `inst_valid`=0, `fetch_adel`=0, `br_pend`=0.
- First `inst_req` appears in the cycle after `rst` deasserts, if not stalled.
- `inst_valid` rises in the cycle after `inst_data_ok`, so it is registered.
- Back-to-back: handoff in cycle N gives `inst_req` in N+1. Minimum 3 cycles per instruction with zero-wait memory.
- At most one read outstanding. `inst_req` is never asserted in DATA, HOLD or DRAIN.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined: in IDLE→ADDR, if `pc[1:0] != 0`, no bus request is made. The next state is HOLD with `if_inst`=0 (nop), `if_pc`=`pc`, `inst_valid`=1, `fetch_adel`=1. `fetch_adel` clears at handoff or flush.
- Not defined: `inst_addr = {pc[31:2], 2'b00}`; `fetch_adel` is constant 0.

## Test plan
- Reset release, zero-wait memory returning 32'h24010001 at 32'hBFC00000 -> `inst_req` in cycle 1; `inst_valid`=1 with `if_pc`=BFC00000 in cycle 3; next `inst_addr`=BFC00004.
- `inst_ready`=0 for 5 cycles in HOLD -> `if_inst`/`if_pc` stable, no `inst_req`; first ready cycle hands off and `inst_req` follows next cycle.
- `full`=1 at handoff -> no handoff and no request; PC unchanged until `full` drops.
- Branch to 32'h80001000 captured while in DATA -> instruction after the current one is fetched from 80001000.
- Flush with `new_pc`=32'hBFC00380 in DATA, `inst_data_ok` 2 cycles later -> data dropped, `inst_valid` stays 0, next `inst_addr`=BFC00380.
- With `FETCH_ADEL_CHECK_EN`, branch to 32'h80000002 -> no `inst_req`; `inst_valid`=1, `fetch_adel`=1, `if_inst`=0, `if_pc`=80000002.
